// File: rtl/s298_resp_pkg.sv
// Shared types and defaults for the s298 response compactor.
package s298_resp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned SIG_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h8016;
  localparam logic [15:0] SEED_DEF  = 16'h0000;

  localparam int unsigned RESP_W = 6;

  // Bit positions of the s298 primary outputs on resp_i
  localparam int unsigned RESP_G117 = 0;
  localparam int unsigned RESP_G132 = 1;
  localparam int unsigned RESP_G66  = 2;
  localparam int unsigned RESP_G118 = 3;
  localparam int unsigned RESP_G133 = 4;
  localparam int unsigned RESP_G67  = 5;

endpackage

// File: rtl/s298_misr_core.sv
// Signature register: seed load or one MISR step per enabled edge.
module s298_misr_core
  import s298_resp_pkg::*;
#(
  parameter int unsigned      SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [SIG_W-1:0]  seed,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_next
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_resp_ext;

  assign w_fb       = r_sig[SIG_W-1] ? POLY : '0;
  assign w_resp_ext = {{(SIG_W - RESP_W){1'b0}}, resp};
  assign sig_next   = {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ w_resp_ext;
  assign sig        = r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (load) begin
      r_sig <= seed;
    end else if (shift) begin
      r_sig <= sig_next;
    end
  end

endmodule

// File: rtl/s298_resp_misr.sv
// Windowed MISR compactor for the s298 outputs with valid/ready signature delivery.
module s298_resp_misr
  import s298_resp_pkg::*;
#(
  parameter int unsigned      SIG_W = SIG_W_DEF,
  parameter int unsigned      CNT_W = CNT_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [RESP_W-1:0] resp_i,
  input  logic [SIG_W-1:0]  exp_sig_i,
  input  logic              sig_ready_i,
  output logic              busy_o,
  output logic              sig_valid_o,
  output logic [SIG_W-1:0]  sig_o,
  output logic              pass_o
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;

  logic             w_load;
  logic             w_shift;
  logic [SIG_W-1:0] w_sig;
  logic [SIG_W-1:0] w_sig_next;

  assign w_load  = (r_state == StIdle) && start_i;
  assign w_shift = (r_state == StRun);

  s298_misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .shift    (w_shift),
    .seed     (SEED),
    .resp     (resp_i),
    .sig      (w_sig),
    .sig_next (w_sig_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) begin
            if (len_i != '0) begin
              r_cnt   <= len_i;
              r_state <= StRun;
            end else begin
              // Empty window: the signature is just the seed
              r_pass  <= (SEED == exp_sig_i);
              r_state <= StDone;
            end
          end
        end
        StRun: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
          if (r_cnt <= CNT_W'(1)) begin
            r_pass  <= (w_sig_next == exp_sig_i);
            r_state <= StDone;
          end
        end
        StDone: begin
          if (sig_ready_i) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o      = (r_state != StIdle);
  assign sig_valid_o = (r_state == StDone);
  assign sig_o       = w_sig;
  assign pass_o      = r_pass;

endmodule

// File: tb/tb_s298_resp_misr.sv
// Directed bench for s298_resp_misr with a queue of expected signatures.
module tb_s298_resp_misr;

  localparam logic [15:0] POLY = 16'h8016;
  localparam logic [15:0] SEED = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [15:0] len_i;
  logic [5:0]  resp_i;
  logic [15:0] exp_sig_i;
  logic        sig_ready_i;
  logic        busy_o;
  logic        sig_valid_o;
  logic [15:0] sig_o;
  logic        pass_o;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  s298_resp_misr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .resp_i      (resp_i),
    .exp_sig_i   (exp_sig_i),
    .sig_ready_i (sig_ready_i),
    .busy_o      (busy_o),
    .sig_valid_o (sig_valid_o),
    .sig_o       (sig_o),
    .pass_o      (pass_o)
  );

  function automatic logic [15:0] mnext(input logic [15:0] s, input logic [5:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {10'b0, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: zeros, 1: single 6'h01 on first cycle, 2: random
  task automatic run_win(input string tag, input int len, input logic [15:0] exp_in,
                         input int mode, output logic [15:0] sig_model);
    logic [5:0]  pat[$];
    logic [15:0] s;
    int          lat;
    exp_t        e;
    s = SEED;
    for (int k = 0; k < len; k++) begin
      logic [5:0] r;
      if (mode == 0)      r = 6'h00;
      else if (mode == 1) r = (k == 0) ? 6'h01 : 6'h00;
      else                r = 6'($urandom);
      pat.push_back(r);
      s = mnext(s, r);
    end
    sig_model = s;
    sb.push_back('{sig: s, pass: (s == exp_in)});
    exp_sig_i = exp_in;
    start_i   = 1'b1;
    len_i     = 16'(len);
    step();
    start_i = 1'b0;
    len_i   = 16'h0000;
    lat     = 1;
    check({tag, ".busy"}, 32'(busy_o), 32'd1);
    for (int k = 0; k < len; k++) begin
      resp_i = pat[k];
      step();
      lat++;
    end
    resp_i = 6'h00;
    while (!sig_valid_o && lat < len + 8) begin
      step();
      lat++;
    end
    check({tag, ".valid"}, 32'(sig_valid_o), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(len + 1));
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".sig"}, 32'(sig_o), 32'(e.sig));
      check({tag, ".pass"}, 32'(pass_o), 32'(e.pass));
    end
  endtask

  task automatic ack(input string tag, input logic [15:0] sig_exp);
    sig_ready_i = 1'b1;
    step();
    sig_ready_i = 1'b0;
    check({tag, ".ack_busy"}, 32'(busy_o), 32'd0);
    check({tag, ".ack_valid"}, 32'(sig_valid_o), 32'd0);
    check({tag, ".ack_sig"}, 32'(sig_o), 32'(sig_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    len_i       = 16'h0000;
    resp_i      = 6'h00;
    exp_sig_i   = 16'h0000;
    sig_ready_i = 1'b0;
    step();
    step();
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.valid", 32'(sig_valid_o), 32'd0);
    check("rst.sig", 32'(sig_o), 32'd0);
    check("rst.pass", 32'(pass_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-window
    start_i = 1'b1;
    len_i   = 16'd100;
    step();
    start_i = 1'b0;
    len_i   = 16'd0;
    for (int k = 0; k < 39; k++) begin
      resp_i = 6'($urandom);
      step();
    end
    check("midrst.busy_before", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.sig", 32'(sig_o), 32'd0);
    check("midrst.busy", 32'(busy_o), 32'd0);
    check("midrst.valid", 32'(sig_valid_o), 32'd0);
    check("midrst.pass", 32'(pass_o), 32'd0);
    resp_i = 6'h00;
    step();
    rst_n = 1'b1;
    step();
    run_win("postrst", 1, 16'h0001, 1, m);
    check("postrst.const", 32'(sig_o), 32'h0001);
    ack("postrst", m);

    // Single pulse shifted
    run_win("pulse_ok", 2, 16'h0002, 1, m);
    check("pulse_ok.const", 32'(sig_o), 32'h0002);
    check("pulse_ok.pass1", 32'(pass_o), 32'd1);
    ack("pulse_ok", m);
    run_win("pulse_bad", 2, 16'h0003, 1, m);
    check("pulse_bad.pass0", 32'(pass_o), 32'd0);
    ack("pulse_bad", m);

    // Feedback path
    run_win("fb", 17, 16'h8016, 1, m);
    check("fb.const", 32'(sig_o), 32'h8016);
    ack("fb", m);

    // Zero length
    run_win("zero", 0, SEED, 0, m);
    check("zero.const", 32'(sig_o), 32'h0000);
    check("zero.pass1", 32'(pass_o), 32'd1);
    ack("zero", m);

    // Handshake stall
    run_win("stall", 5, 16'h1234, 2, m);
    for (int k = 0; k < 10; k++) begin
      resp_i  = 6'($urandom);
      start_i = k[0];
      len_i   = 16'd5;
      step();
      check("stall.sig", 32'(sig_o), 32'(m));
      check("stall.valid", 32'(sig_valid_o), 32'd1);
    end
    resp_i      = 6'h00;
    start_i     = 1'b1;
    sig_ready_i = 1'b1;
    step();
    start_i     = 1'b0;
    sig_ready_i = 1'b0;
    len_i       = 16'd0;
    check("stall.rel_busy", 32'(busy_o), 32'd0);
    check("stall.rel_sig", 32'(sig_o), 32'(m));
    step();
    check("stall.start_ignored", 32'(busy_o), 32'd0);

    // Back-to-back with ready held high
    sig_ready_i = 1'b1;
    for (int w = 0; w < 3; w++) begin
      run_win("b2b", 3, 16'h0000, 0, m);
      check("b2b.pass1", 32'(pass_o), 32'd1);
      step();
      check("b2b.idle", 32'(busy_o), 32'd0);
    end
    sig_ready_i = 1'b0;

    // Random windows, matching and corrupted golden values
    for (int w = 0; w < 4; w++) begin
      int          len;
      logic [15:0] s;
      logic [5:0]  dummy;
      len = int'($urandom_range(1, 20));
      // Seed choice of golden value is independent of the data driven
      s = 16'($urandom);
      dummy = 6'h00;
      run_win("rand", len, s, 2, m);
      ack("rand", m);
      if (dummy != 6'h00) $display("unexpected");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s298_resp_misr.md
# s298_resp_misr

Downstream response compactor for the s298 benchmark netlist. It compresses the six primary outputs of the s298 core into a multiple-input signature register (MISR) over a programmed window of clock cycles. It then presents the signature and a pass/fail compare through a valid/ready handshake. The block sits directly after the s298 core in the benchmark harness and is clocked from the same `clk`.

## Interface
Parameters:
- `SIG_W`, 16: signature width; must be ≥ 6.
- `CNT_W`, 16: window-length counter width.
- `POLY`, 16'h8016: MISR feedback polynomial mask, `SIG_W` bits.
- `SEED`, 16'h0000: signature value loaded at window start.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `start_i`, in, 1: begin a compaction window; sampled only in IDLE.
- `len_i`, in, CNT_W: window length in cycles; sampled together with `start_i`.
- `resp_i`, in, 6: s298 outputs. Bit order from bit 0 to bit 5: G117, G132, G66, G118, G133, G67.
- `exp_sig_i`, in, SIG_W: golden signature; sampled on the cycle that enters DONE.
- `sig_ready_i`, in, 1: consumer accepts the signature.
- `busy_o`, out, 1: high in RUN or DONE.
- `sig_valid_o`, out, 1: signature available; high only in DONE.
- `sig_o`, out, SIG_W: current signature register.
- `pass_o`, out, 1: registered result of `sig == exp_sig_i`; meaningful only while `sig_valid_o` is high.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **MISR update:** `sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp_i`.
- **IDLE:**
  - `sig` is held.
  - If `start_i` is high and `len_i != 0`: load `sig <= SEED`, `cnt <= len_i`, and go to RUN.
  - If `start_i` is high and `len_i == 0`: load `sig <= SEED` and go straight to DONE. No compaction occurs, and `pass_o` compares against SEED.
- **RUN:**
  - On every edge: `sig <= sig_next` and `cnt <= cnt - 1`.
  - When `cnt == 1` at that edge, go to DONE and register `pass_o <= (sig_next == exp_sig_i)`.
  - `start_i` and `len_i` are ignored in this state.
- **DONE:**
  - `sig` is frozen and `sig_valid_o` is high.
  - On an edge with `sig_ready_i` high, go to IDLE; `sig_o` keeps its value.
  - `start_i` is ignored in DONE, including when `start_i` and `sig_ready_i` are high on the same edge; `start_i` is honoured from IDLE on the following cycle.
- The counter never wraps: it is only decremented in RUN while `cnt >= 1`.
- **Reset:**
  - Reset may be asserted at any point, including mid-window or mid-handshake.
  - Asserting `rst_n` low immediately forces state = IDLE, `sig = 0`, `cnt = 0`, `pass_o = 0`.
  - Outputs during reset: `busy_o = 0`, `sig_valid_o = 0`, `sig_o = 0`, `pass_o = 0`.
  - The next `start_i` after reset release behaves normally.

## Timing
- If `start_i` is sampled at edge t, `resp_i` is compacted at edges t+1 through t+N, where N = `len_i`.
- `sig_valid_o` rises after edge t+N.
- Latency from `start_i` to `sig_valid_o` is N+1 cycles (1 cycle when N = 0).
- `busy_o` rises after edge t and falls after the edge where `sig_ready_i` is accepted.
- The handshake completes on the first edge with `sig_valid_o && sig_ready_i`. `sig_ready_i` may be held high permanently, giving a 1-cycle DONE state.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.

## Structure
- Package `s298_resp_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - default `SIG_W`, `POLY` and `SEED`;
  - the `resp_i` bit index constants RESP_G117 to RESP_G67.
- Sub-module `s298_misr_core` contains the signature register only. Its ports are clk, rst_n, `load`, `shift`, `seed` and `resp`, and it is parameterised by `SIG_W` and `POLY`. The FSM, counter and compare live in the top module.

## Test plan
- **Reset mid-window:** start with `len_i = 100`, pull `rst_n` low at cycle 40 → `sig_o = 0`, `busy_o = 0`, `sig_valid_o = 0` immediately. A new start with `len_i = 1`, `resp_i = 6'h01` → `sig_o = 16'h0001`.
- **Single pulse shifted:** start with `len_i = 2`, `resp_i = 6'h01` then `6'h00` → `sig_o = 16'h0002`, `sig_valid_o` 3 cycles after start. With `exp_sig_i = 16'h0002` → `pass_o = 1`; with `16'h0003` → `pass_o = 0`.
- **Feedback path:** start with `len_i = 17`, `resp_i = 6'h01` on the first cycle then zeros. After 16 shifts the bit reaches the MSB, so the 17th shift gives `sig_o = POLY = 16'h8016`.
- **Zero length:** `len_i = 0` with `exp_sig_i = SEED` → DONE after 1 cycle, `sig_o = 16'h0000`, `pass_o = 1`.
- **Handshake stall:** hold `sig_ready_i = 0` for 10 cycles in DONE while toggling `resp_i` and pulsing `start_i` → `sig_o` is unchanged and `sig_valid_o` stays high. Raising `sig_ready_i` returns to IDLE in 1 edge, and a `start_i` pulse in the same cycle is ignored.
- **Back-to-back windows:** `sig_ready_i` tied high, `start_i` pulsed on the first IDLE cycle → each window with `len_i = 3` and all-zero `resp_i` ends with `sig_o = 16'h0000`, `pass_o = 1` against `exp_sig_i = 0`.
